digi_scan_driver: RTL and testbench

- Parametrised, time-multiplexed seven-segment driver for N_DIGITS hex digits.
- Replaces one-7-bit-bus-per-digit outputs with one shared segment bus plus one-hot anode select.
- Adds per-digit blanking, decimal points, 16-level brightness PWM and tear-free frame-synchronous updates.
- Sits between the CPU's memory-mapped display register and the board's digit pins.

---
 rtl/digi_pkg.sv | 14 +
 rtl/digi_hex_decode.sv | 11 +
 rtl/digi_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_digi_scan_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digi_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyph table
// (active-high {g,f,e,d,c,b,a}) and the number of brightness levels.
package digi_pkg;

  localparam int BRIGHT_LEVELS = 16;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/digi_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module digi_hex_decode
  import digi_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/digi_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous double buffering,
// per-digit blanking/dp and PWM brightness. DIGI_SCAN_LZS_EN adds leading-zero suppression.
module digi_scan_driver
  import digi_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SLOT_CYCLES    = 1024,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    sysclk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic [3:0]              bright_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [N_DIGITS-1:0]     an_out,
  output logic                    frame_tick
);

  localparam int SW   = $clog2(SLOT_CYCLES);
  localparam int DW   = $clog2(N_DIGITS);
  localparam int STEP = SLOT_CYCLES / BRIGHT_LEVELS;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return (SEG_ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return (SEG_ACTIVE_LOW != 0) ? ~d : d;
  endfunction

  // Anode-on window length in cycles for a brightness code: (b+1)/16 of a slot.
  function automatic logic [SW:0] duty_limit(input logic [3:0] b);
    return (SW + 1)'((int'(b) + 1) * STEP);
  endfunction

  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           digit_idx;
  logic                    wrapped;

  logic [4*N_DIGITS-1:0]   pend_value;
  logic [N_DIGITS-1:0]     pend_dp;
  logic [N_DIGITS-1:0]     pend_blank;
  logic [3:0]              pend_bright;
  logic                    pend_valid;

  logic [4*N_DIGITS-1:0]   act_value;
  logic [N_DIGITS-1:0]     act_dp;
  logic [N_DIGITS-1:0]     act_blank;
  logic [3:0]              act_bright;
  logic                    act_shown;

  logic [N_DIGITS-1:0]     lz_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              dec_seg;
  logic                    pwm_on;
  logic                    lit;
  logic                    boundary;

  logic [6:0]              seg_p0;
  logic                    dp_p0;
  logic [N_DIGITS-1:0]     an_p0;
  logic                    tick_p0;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [N_DIGITS-1:0]     an_p1;
  logic                    tick_p1;

`ifdef DIGI_SCAN_LZS_EN
  // A digit is hidden when it and every more-significant digit are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (act_value[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx == DW'(i)) begin
        cur_nib   = act_value[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i] | lz_mask[i];
      end
    end
  end

  digi_hex_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Stage p0: combinational selection from the current counter state.
  assign boundary = (slot_cnt == SLOT_LAST) && (digit_idx == DIGIT_LAST);
  assign pwm_on   = {1'b0, slot_cnt} < duty_limit(act_bright);
  assign lit      = act_shown && !cur_blank && pwm_on;

  always_comb begin
    an_p0   = lit ? ~(N_DIGITS'(1) << digit_idx) : '1;
    seg_p0  = act_shown ? seg_pol(dec_seg) : SEG_OFF;
    dp_p0   = act_shown ? dp_pol(cur_dp) : DP_OFF;
    tick_p0 = wrapped && (slot_cnt == '0) && (digit_idx == '0);
  end

  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      wrapped   <= 1'b0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
      if (digit_idx == DIGIT_LAST) wrapped <= 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Commit happens before a same-edge load so the new data stays pending.
  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      pend_value  <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_bright <= '0;
      pend_valid  <= 1'b0;
      act_value   <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_bright  <= '0;
      act_shown   <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_value  <= pend_value;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        act_bright <= pend_bright;
        act_shown  <= 1'b1;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_value  <= value_in;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
        pend_bright <= bright_in;
        pend_valid  <= 1'b1;
      end
    end
  end

  // Stage p1: registered pin drivers.
  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      seg_p1  <= SEG_OFF;
      dp_p1   <= DP_OFF;
      an_p1   <= '1;
      tick_p1 <= 1'b0;
    end else begin
      seg_p1  <= seg_p0;
      dp_p1   <= dp_p0;
      an_p1   <= an_p0;
      tick_p1 <= tick_p0;
    end
  end

  assign seg_out    = seg_p1;
  assign dp_out     = dp_p1;
  assign an_out     = an_p1;
  assign frame_tick = tick_p1;

endmodule

// File: tb/tb_digi_scan_driver.sv
// Self-checking bench for digi_scan_driver (4 digits, 32-cycle slots, low-true segments).
module tb_digi_scan_driver;

  localparam int ND    = 4;
  localparam int SC    = 32;
  localparam int FRAME = ND * SC;

  logic        sysclk    = 1'b0;
  logic        Reset_n   = 1'b0;
  logic        load      = 1'b0;
  logic [15:0] value_in  = '0;
  logic [3:0]  dp_in     = '0;
  logic [3:0]  blank_in  = '0;
  logic [3:0]  bright_in = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  always #5 sysclk = ~sysclk;

  digi_scan_driver #(
    .N_DIGITS       (ND),
    .SLOT_CYCLES    (SC),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .sysclk     (sysclk),
    .Reset_n    (Reset_n),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .bright_in  (bright_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  int checks   = 0;
  int failures = 0;

  // Standard hex glyphs, segment bit 0 = a ... bit 6 = g, lit = 1.
  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: elapsed cycles since reset determine frame position.
  int          m_cnt     = 0;
  int          shown_pos = -1;
  bit          m_ready   = 1'b0;
  logic [15:0] p_val, a_val;
  logic [3:0]  p_dp, a_dp, p_bl, a_bl, p_br, a_br;
  bit          p_vld, a_on;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_tick;

  function automatic bit lz_hidden(input logic [15:0] v, input int d);
    bit hid;
    hid = (d != 0);
    for (int k = 0; k < ND; k++)
      if (k >= d && v[4*k +: 4] != 4'h0) hid = 1'b0;
`ifdef DIGI_SCAN_LZS_EN
    return hid;
`else
    return hid & 1'b0;
`endif
  endfunction

  always @(posedge sysclk) begin
    int pos, dig, slot;
    bit hide;
    if (!Reset_n) begin
      m_cnt = 0; shown_pos = -1;
      p_val = '0; p_dp = '0; p_bl = '0; p_br = '0; p_vld = 1'b0;
      a_val = '0; a_dp = '0; a_bl = '0; a_br = '0; a_on = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      m_ready = 1'b1;
    end else begin
      pos  = m_cnt % FRAME;
      dig  = pos / SC;
      slot = pos % SC;
      hide = a_bl[dig] || lz_hidden(a_val, dig);
      e_seg  = a_on ? ~glyph[a_val[4*dig +: 4]] : 7'h7F;
      e_dp   = a_on ? ~a_dp[dig] : 1'b1;
      e_an   = (a_on && !hide && slot < (int'(a_br) + 1) * SC / 16) ? ~(4'b0001 << dig) : 4'hF;
      e_tick = (pos == 0) && (m_cnt > 0);
      shown_pos = pos;
      if (pos == FRAME - 1 && p_vld) begin
        a_val = p_val; a_dp = p_dp; a_bl = p_bl; a_br = p_br; a_on = 1'b1; p_vld = 1'b0;
      end
      if (load) begin
        p_val = value_in; p_dp = dp_in; p_bl = blank_in; p_br = bright_in; p_vld = 1'b1;
      end
      m_cnt++;
    end
  end

  always @(negedge sysclk) begin
    if (m_ready) begin
      checks++;
      if (an_out !== e_an || seg_out !== e_seg || dp_out !== e_dp || frame_tick !== e_tick) begin
        failures++;
        $display("FAIL model pos=%0d got an=%b seg=%h dp=%b tick=%b want an=%b seg=%h dp=%b tick=%b",
                 shown_pos, an_out, seg_out, dp_out, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wait_shown(input int p);
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (shown_pos != p && n < 400);
    if (shown_pos != p) begin
      checks++;
      failures++;
      $display("FAIL wait_shown got=%0d want=%0d", shown_pos, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] br);
    value_in = v; dp_in = dp; blank_in = bl; bright_in = br; load = 1'b1;
    @(negedge sysclk);
    load = 1'b0;
  endtask

  initial begin
    int lowcnt, a2, dplo, dpbad, dark, ndig;
    bit [3:0] seen;

    repeat (3) @(negedge sysclk);
    lit("reset_an", int'(an_out), 'hF);
    lit("reset_seg", int'(seg_out), 'h7F);
    lit("reset_dp", int'(dp_out), 1);
    lit("reset_tick", int'(frame_tick), 0);
    Reset_n = 1'b1;
    repeat (5) @(negedge sysclk);
    lit("idle_an", int'(an_out), 'hF);

    // Basic scan of 0x1234 at full brightness.
    do_load(16'h1234, 4'b0000, 4'b0000, 4'd15);
    wait_shown(0);
    lit("first_tick", int'(frame_tick), 1);
    lit("d0_an", int'(an_out), 'hE);
    lit("d0_seg", int'(seg_out), 'h19);
    wait_shown(32);
    lit("d1_an", int'(an_out), 'hD);
    lit("d1_seg", int'(seg_out), 'h30);
    wait_shown(64);
    lit("d2_an", int'(an_out), 'hB);
    lit("d2_seg", int'(seg_out), 'h24);
    wait_shown(96);
    lit("d3_an", int'(an_out), 'h7);
    lit("d3_seg", int'(seg_out), 'h79);

    // Brightness 3: anode on for 8 of 32 cycles.
    do_load(16'h1234, 4'b0000, 4'b0000, 4'd3);
    wait_shown(0);
    lowcnt = 0;
    for (int i = 0; i < SC; i++) begin
      if (an_out !== 4'hF) lowcnt++;
      if (i == 7) lit("pwm_last_on", int'(an_out), 'hE);
      if (i == 8) lit("pwm_first_off", int'(an_out), 'hF);
      @(negedge sysclk);
    end
    lit("pwm_low_cycles", lowcnt, 8);

    // Tear-free update.
    do_load(16'h5555, 4'b0000, 4'b0000, 4'd15);
    wait_shown(0);
    lit("five_seg", int'(seg_out), 'h12);
    wait_shown(40);
    do_load(16'hAAAA, 4'b0000, 4'b0000, 4'd15);
    wait_shown(64);
    lit("old_seg_d2", int'(seg_out), 'h12);
    wait_shown(96);
    lit("old_seg_d3", int'(seg_out), 'h12);
    wait_shown(0);
    lit("new_tick", int'(frame_tick), 1);
    lit("new_seg", int'(seg_out), 'h08);
    lit("new_an", int'(an_out), 'hE);

    // Blank digit 2, dp on digit 0.
    do_load(16'h1234, 4'b0001, 4'b0100, 4'd15);
    wait_shown(0);
    a2 = 0; dplo = 0; dpbad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (an_out[2] === 1'b0) a2++;
      if (dp_out === 1'b0) dplo++;
      if (dp_out === 1'b0 && shown_pos >= SC) dpbad++;
      @(negedge sysclk);
    end
    lit("blank_d2_low", a2, 0);
    lit("dp_low_cycles", dplo, 32);
    lit("dp_outside_d0", dpbad, 0);

    // Reset during digit 2.
    wait_shown(70);
    Reset_n = 1'b0;
    @(negedge sysclk);
    Reset_n = 1'b1;
    lit("midrst_an", int'(an_out), 'hF);
    lit("midrst_seg", int'(seg_out), 'h7F);
    lit("midrst_dp", int'(dp_out), 1);
    dark = 0;
    for (int i = 0; i < 300; i++) begin
      if (an_out !== 4'hF || seg_out !== 7'h7F) dark++;
      @(negedge sysclk);
    end
    lit("post_reset_dark", dark, 0);

    // Leading zeros.
    do_load(16'h0030, 4'b0000, 4'b0000, 4'd15);
    wait_shown(0);
    seen = '0;
    for (int i = 0; i < FRAME; i++) begin
      for (int d = 0; d < ND; d++)
        if (an_out[d] === 1'b0) seen[d] = 1'b1;
      if (i == 0)  lit("lz_d0_seg", int'(seg_out), 'h40);
      if (i == SC) lit("lz_d1_seg", int'(seg_out), 'h30);
      @(negedge sysclk);
    end
    ndig = 0;
    for (int d = 0; d < ND; d++) if (seen[d]) ndig++;
`ifdef DIGI_SCAN_LZS_EN
    lit("lz_lit_digits", ndig, 2);
`else
    lit("lz_lit_digits", ndig, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
